// File: rtl/tone_sweep_controller.sv
// tone_sweep_controller: sample-rate clock enable plus linear phase-increment
// sweep sequencer (start, step, count, dwell) driving the sinewave NCO.
module tone_sweep_controller #(
   parameter int PHASE_WIDTH = 64,
   parameter int CE_DIV      = 1024,
   parameter int DWELL_WIDTH = 16,
   parameter int STEPS_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [PHASE_WIDTH-1:0] start_inc,
   input  logic [PHASE_WIDTH-1:0] step_inc,
   input  logic [STEPS_WIDTH-1:0] num_steps,
   input  logic [DWELL_WIDTH-1:0] dwell,
   output logic                   sample_clk_ce,
   output logic [PHASE_WIDTH-1:0] phase_increment,
   output logic [STEPS_WIDTH-1:0] step_idx,
   output logic                   busy,
   output logic                   done
);

   localparam int CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CE_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                 state, state_nx;
   logic [CNT_W-1:0]       ce_cnt;
   logic [PHASE_WIDTH-1:0] step_inc_q;
   logic [STEPS_WIDTH-1:0] num_steps_q;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_cnt, dwell_last;
   logic [PHASE_WIDTH-1:0] phase_nx;
   logic [STEPS_WIDTH-1:0] idx_nx;
   logic [DWELL_WIDTH-1:0] dwell_cnt_nx;
   logic                   busy_nx, done_nx, latch;

   // Dwell of 0 behaves as 1, so the terminal count is max(dwell,1)-1.
   assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

   // Free-running sample-rate divider; never resynchronised by start/abort.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ce_cnt        <= '0;
         sample_clk_ce <= 1'b0;
      end else begin
         sample_clk_ce <= (ce_cnt == CNT_LAST);
         ce_cnt        <= (ce_cnt == CNT_LAST) ? '0 : ce_cnt + 1'b1;
      end
   end

   // State, registered outputs and latched sweep configuration.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state           <= S_IDLE;
         phase_increment <= '0;
         step_idx        <= '0;
         dwell_cnt       <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         step_inc_q      <= '0;
         num_steps_q     <= '0;
         dwell_q         <= '0;
      end else begin
         state           <= state_nx;
         phase_increment <= phase_nx;
         step_idx        <= idx_nx;
         dwell_cnt       <= dwell_cnt_nx;
         busy            <= busy_nx;
         done            <= done_nx;
         if (latch) begin
            step_inc_q  <= step_inc;
            num_steps_q <= num_steps;
            dwell_q     <= dwell;
         end
      end
   end

   // Next-state and next-output decode; dwell advances only on sample enables.
   always_comb begin
      state_nx     = state;
      phase_nx     = phase_increment;
      idx_nx       = step_idx;
      dwell_cnt_nx = dwell_cnt;
      busy_nx      = busy;
      done_nx      = 1'b0;
      latch        = 1'b0;
      case (state)
         S_IDLE: begin
            phase_nx     = '0;
            idx_nx       = '0;
            dwell_cnt_nx = '0;
            busy_nx      = 1'b0;
            if (start && !abort) begin
               if (num_steps != '0) begin
                  latch    = 1'b1;
                  state_nx = S_RUN;
                  busy_nx  = 1'b1;
                  phase_nx = start_inc;
               end else begin
                  // Empty sweep completes immediately without entering RUN.
                  done_nx = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_nx     = S_IDLE;
               busy_nx      = 1'b0;
               phase_nx     = '0;
               idx_nx       = '0;
               dwell_cnt_nx = '0;
            end else if (sample_clk_ce) begin
               if (dwell_cnt == dwell_last) begin
                  dwell_cnt_nx = '0;
                  if (step_idx == num_steps_q - 1'b1) begin
                     state_nx = S_DONE;
                     busy_nx  = 1'b0;
                     done_nx  = 1'b1;
                     phase_nx = '0;
                     idx_nx   = '0;
                  end else begin
                     idx_nx   = step_idx + 1'b1;
                     phase_nx = phase_increment + step_inc_q;
                  end
               end else begin
                  dwell_cnt_nx = dwell_cnt + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tone_sweep_controller.sv
// tb_tone_sweep_controller: randomized self-checking bench for the tone sweep
// sequencer, using an expected per-sample-enable increment queue as reference.
module tb_tone_sweep_controller;

   localparam int CE_DIV = 4;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [63:0] start_inc = '0;
   logic [63:0] step_inc = '0;
   logic [11:0] num_steps = '0;
   logic [15:0] dwell = '0;
   logic        sample_clk_ce;
   logic [63:0] phase_increment;
   logic [11:0] step_idx;
   logic        busy;
   logic        done;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   tone_sweep_controller #(
      .PHASE_WIDTH (64),
      .CE_DIV      (CE_DIV),
      .DWELL_WIDTH (16),
      .STEPS_WIDTH (12)
   ) dut (
      .clk             (clk),
      .arst            (arst),
      .start           (start),
      .abort           (abort),
      .start_inc       (start_inc),
      .step_inc        (step_inc),
      .num_steps       (num_steps),
      .dwell           (dwell),
      .sample_clk_ce   (sample_clk_ce),
      .phase_increment (phase_increment),
      .step_idx        (step_idx),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   // Edges seen since reset release; the enable is due on every CE_DIV-th edge.
   always @(posedge clk or posedge arst) begin
      if (arst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   function automatic bit exp_ce();
      return (cyc != 0) && (cyc % CE_DIV == 0);
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({sample_clk_ce, busy, done, step_idx, phase_increment} !== 79'd0) begin
         bad++;
         $display("FAIL reset: got ce=%0b busy=%0b done=%0b idx=%0d inc=%0h, want all zero",
                  sample_clk_ce, busy, done, step_idx, phase_increment);
      end
      @(negedge clk);
      arst = 1'b0;
      tick();
   endtask

   task automatic test_ce_idle();
      for (int i = 0; i < 20; i++) begin
         total++;
         if (sample_clk_ce !== exp_ce()) begin
            bad++;
            $display("FAIL ce_idle: cycle %0d got ce=%0b want %0b", cyc, sample_clk_ce, exp_ce());
         end
         total++;
         if ({busy, done, phase_increment} !== 66'd0) begin
            bad++;
            $display("FAIL idle_out: got busy=%0b done=%0b inc=%0h want 0", busy, done, phase_increment);
         end
         tick();
      end
   endtask

   task automatic do_sweep(input logic [63:0] si, input logic [63:0] st, input int n, input int d,
                           input int ab, input bit repulse, input string name);
      logic [63:0] qv[$];
      int          qi[$];
      int          guard;
      int          reps;
      reps = (d == 0) ? 1 : d;
      for (int i = 0; i < n; i++)
         for (int r = 0; r < reps; r++) begin
            qv.push_back(si + st * 64'(i));
            qi.push_back(i);
         end
      start = 1'b1; abort = 1'b0;
      start_inc = si; step_inc = st; num_steps = 12'(n); dwell = 16'(d);
      tick();
      start = 1'b0;
      start_inc = rand64(); step_inc = rand64(); num_steps = 12'($urandom); dwell = 16'($urandom);
      guard = 0;
      while (qv.size() > 0 && guard < 20000) begin
         guard++;
         total++;
         if ({busy, done, step_idx, phase_increment} !== {1'b1, 1'b0, 12'(qi[0]), qv[0]}) begin
            bad++;
            $display("FAIL %s_run: got busy=%0b done=%0b idx=%0d inc=%0h want busy=1 done=0 idx=%0d inc=%0h",
                     name, busy, done, step_idx, phase_increment, qi[0], qv[0]);
         end
         total++;
         if (sample_clk_ce !== exp_ce()) begin
            bad++;
            $display("FAIL %s_ce: got ce=%0b want %0b", name, sample_clk_ce, exp_ce());
         end
         if (ab >= 0 && qi[0] == ab) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            total++;
            if ({busy, done, step_idx, phase_increment} !== 78'd0) begin
               bad++;
               $display("FAIL %s_abort: got busy=%0b done=%0b idx=%0d inc=%0h want all zero",
                        name, busy, done, step_idx, phase_increment);
            end
            for (int i = 0; i < 3 * CE_DIV * reps; i++) begin
               tick();
               total++;
               if ({busy, done} !== 2'b00) begin
                  bad++;
                  $display("FAIL %s_no_done: got busy=%0b done=%0b want 0 0", name, busy, done);
               end
            end
            return;
         end
         if (exp_ce()) begin
            void'(qv.pop_front());
            void'(qi.pop_front());
         end
         start = (repulse && qv.size() > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
         tick();
      end
      start = 1'b0;
      if (guard >= 20000) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d cycles want completion", name, guard);
      end
      total++;
      if ({busy, done, step_idx, phase_increment} !== {1'b0, 1'b1, 12'd0, 64'd0}) begin
         bad++;
         $display("FAIL %s_done: got busy=%0b done=%0b idx=%0d inc=%0h want busy=0 done=1 idx=0 inc=0",
                  name, busy, done, step_idx, phase_increment);
      end
      tick();
      total++;
      if ({busy, done, phase_increment} !== 66'd0) begin
         bad++;
         $display("FAIL %s_after: got busy=%0b done=%0b inc=%0h want 0", name, busy, done, phase_increment);
      end
      tick();
   endtask

   task automatic test_sweep_basic();
      do_sweep(64'd100, 64'd50, 3, 2, -1, 1'b0, "basic");
   endtask

   task automatic test_wrap();
      do_sweep(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1, -1, 1'b0, "wrap");
   endtask

   task automatic test_abort();
      do_sweep(64'd100, 64'd50, 3, 2, 1, 1'b0, "abort");
   endtask

   task automatic test_zero_steps();
      start = 1'b1; abort = 1'b0; num_steps = 12'd0; dwell = 16'd2;
      tick();
      start = 1'b0;
      total++;
      if ({busy, done} !== 2'b01) begin
         bad++;
         $display("FAIL zero_done: got busy=%0b done=%0b want busy=0 done=1", busy, done);
      end
      tick();
      total++;
      if ({busy, done} !== 2'b00) begin
         bad++;
         $display("FAIL zero_after: got busy=%0b done=%0b want 0 0", busy, done);
      end
      start = 1'b1; abort = 1'b1; num_steps = 12'd3; start_inc = 64'd9;
      tick();
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 6; i++) begin
         total++;
         if ({busy, done, phase_increment} !== 66'd0) begin
            bad++;
            $display("FAIL start_abort: got busy=%0b done=%0b inc=%0h want 0", busy, done, phase_increment);
         end
         tick();
      end
   endtask

   task automatic test_dwell_zero_repulse();
      do_sweep(64'd7, 64'd3, 3, 0, -1, 1'b1, "dwell0");
      do_sweep(64'd500, 64'd20, 2, 3, -1, 1'b1, "repulse");
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++)
         do_sweep(rand64(), rand64(), $urandom_range(1, 5), $urandom_range(0, 3), -1,
                  1'($urandom_range(0, 1)), "random");
   endtask

   task automatic test_arst_mid();
      start = 1'b1; start_inc = 64'd42; step_inc = 64'd5; num_steps = 12'd4; dwell = 16'd2;
      tick();
      start = 1'b0;
      repeat (9) tick();
      #2;
      arst = 1'b1;
      #1;
      total++;
      if ({sample_clk_ce, busy, done, step_idx, phase_increment} !== 79'd0) begin
         bad++;
         $display("FAIL arst_mid: got ce=%0b busy=%0b done=%0b idx=%0d inc=%0h want all zero",
                  sample_clk_ce, busy, done, step_idx, phase_increment);
      end
      @(negedge clk);
      arst = 1'b0;
      tick();
      for (int i = 0; i < 12; i++) begin
         total++;
         if ({sample_clk_ce, busy, done} !== {exp_ce(), 2'b00}) begin
            bad++;
            $display("FAIL arst_restart: cycle %0d got ce=%0b busy=%0b done=%0b want ce=%0b busy=0 done=0",
                     cyc, sample_clk_ce, busy, done, exp_ce());
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_ce_idle();
      test_sweep_basic();
      test_wrap();
      test_abort();
      test_zero_steps();
      test_dwell_zero_repulse();
      test_random();
      test_arst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
